// File: rtl/phase_diff_acc.sv
// Wrapped phase-difference averager feeding the phase-to-speed stage.
// Averages 2^LOG2N consecutive wrapped deltas and emits the floor mean.
module phase_diff_acc #(
   parameter int LOG2N = 3,
   parameter int PW    = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [PW-1:0] in_phase,
   output logic [PW-1:0] out_phasediff,
   output logic          data_rdy,
   output logic          busy
);

   localparam int AW = PW + LOG2N;
   localparam int CW = (LOG2N > 0) ? LOG2N : 1;

   localparam logic signed [PW:0] HALF = (PW+1)'(184320);
   localparam logic signed [PW:0] FULL = (PW+1)'(368640);
   localparam logic [CW-1:0] CLAST = CW'((1 << LOG2N) - 1);

   typedef enum logic {EMPTY, ACCUM} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         prev_q, prev_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         out_d;
   logic                  rdy_d;

   logic signed [PW:0]    d_raw, d_wrap;
   logic signed [PW-1:0]  d;
   logic signed [AW-1:0]  sum;

   assign d_raw = $signed({in_phase[PW-1], in_phase})
                - $signed({prev_q[PW-1], prev_q});

   // one correction is enough: |d_raw| < 360 deg for in-range inputs
   always_comb begin
      d_wrap = d_raw;
      if (d_raw >= HALF)
         d_wrap = d_raw - FULL;
      else if (d_raw < -HALF)
         d_wrap = d_raw + FULL;
   end

   assign d   = PW'(d_wrap);
   assign sum = acc_q + AW'(d);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_phasediff;
      rdy_d   = 1'b0;
      if (clear) begin
         state_d = EMPTY;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (in_valid) begin
         prev_d = in_phase;
         unique case (state_q)
            EMPTY: state_d = ACCUM;
            ACCUM: begin
               if (cnt_q == CLAST) begin
                  out_d = PW'(sum >>> LOG2N);
                  rdy_d = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= EMPTY;
         prev_q        <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         out_phasediff <= '0;
         data_rdy      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         out_phasediff <= out_d;
         data_rdy      <= rdy_d;
         busy          <= (state_d == ACCUM);
      end
   end

endmodule

// File: tb/tb_phase_diff_acc.sv
// Self-checking bench for phase_diff_acc: directed cases plus random
// stream compared against a queue-based floor-mean reference model.
module tb_phase_diff_acc;

   localparam int LOG2N = 3;
   localparam int PW    = 19;
   localparam int N     = 1 << LOG2N;
   localparam int HALF  = 184320;
   localparam int FULL  = 368640;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          in_valid;
   logic [PW-1:0] in_phase;
   logic [PW-1:0] out_phasediff;
   logic          data_rdy;
   logic          busy;

   phase_diff_acc #(.LOG2N(LOG2N), .PW(PW)) dut (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .in_valid      (in_valid),
      .in_phase      (in_phase),
      .out_phasediff (out_phasediff),
      .data_rdy      (data_rdy),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   bit have_ref;
   int ref_ph;
   int dq[$];
   int exp_out;
   bit exp_rdy;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int wrap(input int d);
      if (d >= HALF) return d - FULL;
      if (d < -HALF) return d + FULL;
      return d;
   endfunction

   function automatic int floor_mean(input int s);
      int q;
      q = s / N;
      if ((s % N) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic check_outs(input string tag);
      logic [PW-1:0] eo;
      eo = exp_out[PW-1:0];
      chk({tag, ".rdy"}, 32'(data_rdy), 32'(exp_rdy));
      chk({tag, ".out"}, 32'(out_phasediff), 32'(eo));
      chk({tag, ".busy"}, 32'(busy), 32'(have_ref));
   endtask

   task automatic step(input bit v, input int ph, input bit clr);
      int s;
      clear    = clr;
      in_valid = v;
      in_phase = ph[PW-1:0];
      @(posedge clk);
      #1;
      exp_rdy = 1'b0;
      if (clr) begin
         have_ref = 1'b0;
         dq.delete();
      end else if (v) begin
         if (have_ref) begin
            dq.push_back(wrap(ph - ref_ph));
            if (dq.size() == N) begin
               s = dq.sum();
               exp_out = floor_mean(s);
               exp_rdy = 1'b1;
               dq.delete();
            end
         end
         have_ref = 1'b1;
         ref_ph   = ph;
      end
      in_valid = 1'b0;
      clear    = 1'b0;
      check_outs("step");
   endtask

   task automatic async_reset();
      #2;
      reset = 1'b0;
      #1;
      have_ref = 1'b0;
      dq.delete();
      exp_out = 0;
      exp_rdy = 1'b0;
      check_outs("arst");
      @(posedge clk);
      #1;
      check_outs("arst_hold");
      reset = 1'b1;
   endtask

   task automatic feed(input int base, input int stepv, input int cnt,
                       input int gap);
      for (int i = 0; i < cnt; i++) begin
         step(1'b1, base + i * stepv, 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b0);
      end
   endtask

   int wup[9]   = '{100, 120, 140, 160, -180, -160, -140, -120, -100};
   int wdn[9]   = '{-100, -120, -140, -160, -180, 160, 140, 120, 100};

   initial begin
      reset    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_phase = '0;
      have_ref = 1'b0;
      ref_ph   = 0;
      exp_out  = 0;
      exp_rdy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset");
      reset = 1'b1;

      feed(1024, 1024, 3, 0);
      async_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0);

      feed(0, 1024, 9, 0);

      step(1'b0, 0, 1'b1);
      foreach (wup[i]) step(1'b1, wup[i] * 1024, 1'b0);
      step(1'b0, 0, 1'b1);
      foreach (wdn[i]) step(1'b1, wdn[i] * 1024, 1'b0);

      step(1'b0, 0, 1'b1);
      feed(0, -512, 9, 0);
      step(1'b0, 0, 1'b1);
      feed(0, 0, 8, 0);
      step(1'b1, -1, 1'b0);

      step(1'b0, 0, 1'b1);
      feed(0, 2048, 17, 0);
      step(1'b0, 0, 1'b1);
      feed(0, 2048, 17, 3);

      step(1'b0, 0, 1'b1);
      feed(0, 3072, 5, 0);
      step(1'b1, 50000, 1'b1);
      feed(-5000, -700, 9, 0);

      feed(7000, 4096, 5, 1);
      async_reset();
      feed(-170000, 9000, 9, 0);

      for (int i = 0; i < 3000; i++) begin
         int ph;
         bit v;
         bit c;
         v = ($urandom_range(0, 9) < 7);
         c = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 3) == 0)
            ph = (($urandom_range(0, 1) == 1) ? HALF - 1 : -HALF)
               + int'($urandom_range(0, 2000)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
         else
            ph = int'($urandom_range(0, FULL - 1)) - HALF;
         if (ph >= HALF) ph = HALF - 1;
         if (ph < -HALF) ph = -HALF;
         if ($urandom_range(0, 499) == 0)
            async_reset();
         else
            step(v, ph, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/phase_diff_acc.md
Name: phase_diff_acc

Overview:
Upstream feeder of the phase-to-speed stage. Takes the per-sample instantaneous phase from the phase extractor (CORDIC/atan) and computes the wrapped phase difference between consecutive samples. It averages 2^LOG2N such differences and presents the mean as a signed Q9.10 degrees word with a one-cycle data_rdy strobe. That strobe drives the phase-to-speed converter's in_phasediff/data_rdy inputs directly.

Parameters:
LOG2N, 3, log2 of the number of phase differences averaged per output (N = 8); legal range 0..6.
PW, 19, phase word width; signed two's complement Q9.10, degrees.

Ports:
clk  in  1  system clock, 100 MHz, rising-edge.
reset  in  1  asynchronous, active-low.
clear  in  1  synchronous restart; discards reference sample and partial window.
in_valid  in  1  in_phase is valid this cycle; may be high every cycle.
in_phase  in  PW  instantaneous phase, Q9.10 degrees, caller guarantees range [-180.0, +180.0).
out_phasediff  out  PW  mean wrapped phase difference per sample, Q9.10 degrees.
data_rdy  out  1  one-cycle pulse; out_phasediff updated and valid.
busy  out  1  high while a reference sample is held (state ACCUM).

Behaviour:
- Reset is asynchronous and active-low. When reset=0: state=EMPTY, prev_phase=0, acc=0, cnt=0, out_phasediff=0, data_rdy=0, busy=0. Reset takes effect immediately, mid-window included; a partial window is lost.
- Constants: HALF = 180*1024 = 184320 (0x2D000); FULL = 368640.
- States:
  - EMPTY: no reference sample held. On in_valid: prev_phase<=in_phase, go to ACCUM, no delta produced.
  - ACCUM: on in_valid, compute d = in_phase - prev_phase at PW+1 bits (range (-360,360)).
    - Wrap d: if d >= HALF then d-FULL; else if d < -HALF then d+FULL; else d. Result is PW bits in [-180,180).
    - Update: prev_phase<=in_phase, acc<=acc+d (width PW+LOG2N, sign-extended), cnt<=cnt+1.
- Window completion: on the edge accepting delta number 2^LOG2N (cnt = 2^LOG2N-1):
  - out_phasediff <= (acc+d) >>> LOG2N, an arithmetic shift, truncation toward -inf.
  - data_rdy <= 1 for exactly one cycle.
  - acc<=0, cnt<=0, state stays ACCUM.
- Latency: data_rdy is high in the cycle immediately after the clock edge that sampled the final in_valid.
- Windows are contiguous. The last sample of a window is the reference for the first delta of the next window, so no sample is lost.
- in_valid during the data_rdy cycle is accepted normally into the new window.
- out_phasediff holds its value between pulses. data_rdy=0 whenever there is no completion edge.
- clear=1: state<=EMPTY, acc<=0, cnt<=0, data_rdy<=0, out_phasediff retained. clear has priority over a simultaneous in_valid; that sample is discarded.
- in_valid=0: no state change; gaps of any length are allowed inside a window.
- busy = (state==ACCUM), registered.
- Overflow: |acc| <= 2^LOG2N * 184320 fits PW+LOG2N signed bits for every legal LOG2N. No saturation logic is needed.
- Out-of-range in_phase is unsupported and is not checked. A single wrap correction is still applied.

Test Plan:
- Reset and idle: assert reset=0 mid-run, release, no in_valid for 20 cycles -> out_phasediff=0, data_rdy=0, busy=0 throughout.
- Ramp: in_phase = 0.0, 1.0, ..., 8.0 deg (step 0x00400), in_valid each cycle -> single data_rdy one cycle after the 9th sample; out_phasediff=19'h00400; busy=1 from cycle after the first sample.
- Wrap-around: phases 100, 120, ..., 180→-180 crossing (100,120,140,160,-180,-160,-140,-120,-100) -> out_phasediff=20.0=19'h05000. Mirror the descending sequence -> 19'h7B000 (-20.0).
- Negative and truncation: 8 deltas of -0.5 -> 19'h7FE00. Seven deltas of 0 and one of -1 LSB -> 19'h7FFFF (arithmetic floor, not 0).
- Continuous streaming: 17 back-to-back valid samples of a +2.0 deg ramp -> two data_rdy pulses exactly 8 cycles apart, both 19'h00800. Insert 3-cycle in_valid gaps -> same values, pulses delayed by the gaps.
- clear/reset mid-window: after 4 deltas, pulse clear together with in_valid, then feed 9 samples -> exactly one data_rdy with the new-window mean only, prior out_phasediff held until then. Repeat using async reset → all outputs 0 immediately, without waiting for a clock edge.
